hls_run_controller: RTL

Synthesizable run sequencer for an HLS-generated accelerator with a start/done handshake. It executes a programmed number of back-to-back runs. For each run it pulses the accelerator reset and start, then counts latency cycles until done. It classifies each run as pass, fail, no-check or timeout, and pushes a result record into an internal FIFO for readout. It sits between the accelerator top and a host/debug interface and replaces file-driven result logging with on-chip capture.

---
 rtl/hls_run_pkg.sv | 19 +
 rtl/hls_result_fifo.sv | 37 +++
 rtl/hls_run_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hls_run_pkg.sv
// hls_run_pkg: shared widths, status codes, FSM states and result record for the run controller.
package hls_run_pkg;
   localparam int RUN_W = 8;
   localparam int CYC_W = 32;
   localparam int RET_W = 32;
   localparam logic [1:0] ST_NOCHECK = 2'b00;
   localparam logic [1:0] ST_PASS    = 2'b01;
   localparam logic [1:0] ST_FAIL    = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;
   typedef enum logic [2:0] {S_IDLE, S_DRST, S_START, S_WAIT, S_RECORD, S_DONE} state_t;
   typedef struct packed {
      logic [1:0]       status;
      logic [CYC_W-1:0] cycles;
      logic [RUN_W-1:0] run_idx;
   } result_t;
   function automatic logic [1:0] classify(input logic v, input logic [RET_W-1:0] e, input logic [RET_W-1:0] r);
      return !v ? ST_NOCHECK : (e == r) ? ST_PASS : ST_FAIL;
   endfunction
endpackage

// File: rtl/hls_result_fifo.sv
// hls_result_fifo: first-word-fall-through FIFO with full/empty flags and async active-low reset.
module hls_result_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, rd_q;
   logic         do_push, do_pop;
   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = wr_q == rd_q;
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop) rd_q <= rd_q + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/hls_run_controller.sv
// hls_run_controller: sequences batches of accelerator runs, measures latency,
// classifies each run and queues result records for host readout.
module hls_run_controller
   import hls_run_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int DUT_RST_CYCLES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             go_i,
   input  logic [RUN_W-1:0] cfg_num_runs_i,
   input  logic [CYC_W-1:0] cfg_timeout_i,
   output logic             busy_o,
   output logic             batch_done_o,
   output logic             aborted_o,
   output logic             dut_reset_o,
   output logic             dut_start_o,
   input  logic             dut_done_i,
   input  logic [RET_W-1:0] dut_ret_i,
   input  logic             exp_valid_i,
   input  logic [RET_W-1:0] exp_ret_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [1:0]       res_status_o,
   output logic [CYC_W-1:0] res_cycles_o,
   output logic [RUN_W-1:0] res_run_idx_o
);
   localparam int RCW = $clog2(DUT_RST_CYCLES + 1);
   state_t           state_q;
   logic [RUN_W-1:0] runs_q, idx_q;
   logic [CYC_W-1:0] tmo_q, cnt_q, cnt_d;
   logic [RCW-1:0]   rcnt_q;
   logic             exp_v_q, tmo_hit_q, aborted_q, busy_q, batch_done_q, dut_rst_q, dut_start_q;
   logic [RET_W-1:0] exp_r_q;
   result_t          rec_q, head;
   logic             full, empty, push;
   assign cnt_d = &cnt_q ? cnt_q : cnt_q + CYC_W'(1);
   assign push  = (state_q == S_RECORD) && !full;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         runs_q       <= '0;
         idx_q        <= '0;
         tmo_q        <= '0;
         cnt_q        <= '0;
         rcnt_q       <= '0;
         exp_v_q      <= 1'b0;
         exp_r_q      <= '0;
         rec_q        <= '0;
         tmo_hit_q    <= 1'b0;
         aborted_q    <= 1'b0;
         busy_q       <= 1'b0;
         batch_done_q <= 1'b0;
         dut_rst_q    <= 1'b0;
         dut_start_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (go_i) begin
               runs_q    <= cfg_num_runs_i;
               tmo_q     <= cfg_timeout_i;
               aborted_q <= 1'b0;
               tmo_hit_q <= 1'b0;
               busy_q    <= 1'b1;
               idx_q     <= '0;
               rcnt_q    <= '0;
               state_q   <= (cfg_num_runs_i == '0) ? S_DONE : S_DRST;
               batch_done_q <= cfg_num_runs_i == '0;
            end
            S_DRST: if (rcnt_q == RCW'(DUT_RST_CYCLES - 1)) begin
               state_q     <= S_START;
               dut_rst_q   <= 1'b1;
               dut_start_q <= 1'b1;
               cnt_q       <= CYC_W'(1);
            end else rcnt_q <= rcnt_q + RCW'(1);
            S_START: begin
               dut_start_q <= 1'b0;
               exp_v_q     <= exp_valid_i;
               exp_r_q     <= exp_ret_i;
               cnt_q       <= cnt_d;
               rec_q       <= '{classify(exp_valid_i, exp_ret_i, dut_ret_i), cnt_q, idx_q};
               state_q     <= dut_done_i ? S_RECORD : S_WAIT;
            end
            // Done wins over the watchdog when both land in the same cycle.
            S_WAIT: if (dut_done_i) begin
               rec_q   <= '{classify(exp_v_q, exp_r_q, dut_ret_i), cnt_q, idx_q};
               state_q <= S_RECORD;
            end else if (tmo_q != '0 && cnt_q >= tmo_q) begin
               rec_q     <= '{ST_TIMEOUT, tmo_q, idx_q};
               tmo_hit_q <= 1'b1;
               aborted_q <= 1'b1;
               state_q   <= S_RECORD;
            end else cnt_q <= cnt_d;
            S_RECORD: if (!full) begin
               dut_rst_q <= 1'b0;
               rcnt_q    <= '0;
               if (tmo_hit_q || idx_q == runs_q - RUN_W'(1)) begin
                  state_q      <= S_DONE;
                  batch_done_q <= 1'b1;
               end else begin
                  idx_q   <= idx_q + RUN_W'(1);
                  state_q <= S_DRST;
               end
            end
            S_DONE: begin
               batch_done_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   hls_result_fifo #(.W($bits(result_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .din_i   (rec_q),
      .pop_i   (res_ready_i),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign busy_o        = busy_q;
   assign batch_done_o  = batch_done_q;
   assign aborted_o     = aborted_q;
   assign dut_reset_o   = dut_rst_q;
   assign dut_start_o   = dut_start_q;
   assign res_valid_o   = !empty;
   assign res_status_o  = head.status;
   assign res_cycles_o  = head.cycles;
   assign res_run_idx_o = head.run_idx;
endmodule
